// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus encoded-key outputs between scanner and its neighbours
interface keypad_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [7:0] button;
    logic       key_valid;
    modport master (input row_n, output col_n, button, key_valid);
    modport slave (output row_n, input col_n, button, key_valid);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 active-low keypad, debounces it and emits calculator button codes; KEY_PULSE_EN makes button a one-cycle pulse
module keypad_matrix_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input logic      clk,
    input logic      rst,
    keypad_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEY_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    state_t        state, state_nx;
    logic [3:0]    r1, r2;
    logic [DW-1:0] dwell;
    logic [1:0]    col, col_nx, row;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [7:0]    cand, cand_nx, button, button_nx, code;
    logic          key_valid, kv_nx, sample, any, hit, released, last;
    assign sample   = dwell == DW'(SCAN_DIV - 1);
    assign any      = r2 != 4'hF;
    assign row      = !r2[0] ? 2'd0 : !r2[1] ? 2'd1 : !r2[2] ? 2'd2 : 2'd3;
    assign code     = {2'b00, col, 2'b01, row};
    assign hit      = any && code == cand;
    assign released = r2[cand[1:0]];
    assign cnt_inc  = cnt + 1'b1;
    assign last     = cnt_inc == CW'(DEBOUNCE_CNT);
    assign kp.col_n     = ~(4'b0001 << col);
    assign kp.button    = button;
    assign kp.key_valid = key_valid;
    // next-state and output decisions, taken only at the dwell sample point
    always_comb begin
        state_nx  = state;
        col_nx    = col;
        cnt_nx    = cnt;
        cand_nx   = cand;
        button_nx = PULSE ? 8'h00 : button;
        kv_nx     = 1'b0;
        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (!any) col_nx = col + 2'd1;
                    else begin
                        cand_nx  = code;
                        cnt_nx   = CW'(1);
                        state_nx = DEBOUNCE;
                        if (DEBOUNCE_CNT == 1) begin
                            button_nx = code;
                            kv_nx     = 1'b1;
                            state_nx  = HELD;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!hit) begin
                        cnt_nx   = '0;
                        col_nx   = col + 2'd1;
                        state_nx = SCAN;
                    end else if (last) begin
                        button_nx = cand;
                        kv_nx     = 1'b1;
                        state_nx  = HELD;
                    end else cnt_nx = cnt_inc;
                end
                HELD: begin
                    if (released) begin
                        cnt_nx   = CW'(1);
                        state_nx = RELEASE;
                        if (DEBOUNCE_CNT == 1) begin
                            button_nx = 8'h00;
                            cnt_nx    = '0;
                            col_nx    = col + 2'd1;
                            state_nx  = SCAN;
                        end
                    end
                end
                RELEASE: begin
                    if (!released) begin
                        cnt_nx   = '0;
                        state_nx = HELD;
                    end else if (last) begin
                        button_nx = 8'h00;
                        cnt_nx    = '0;
                        col_nx    = col + 2'd1;
                        state_nx  = SCAN;
                    end else cnt_nx = cnt_inc;
                end
                default: state_nx = SCAN;
            endcase
        end
    end
    // registers: row synchroniser, dwell timer and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            r1        <= 4'hF;
            r2        <= 4'hF;
            dwell     <= '0;
            state     <= SCAN;
            col       <= 2'd0;
            cnt       <= '0;
            cand      <= 8'h00;
            button    <= 8'h00;
            key_valid <= 1'b0;
        end else begin
            r1        <= kp.row_n;
            r2        <= r1;
            dwell     <= sample ? '0 : dwell + 1'b1;
            state     <= state_nx;
            col       <= col_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            button    <= button_nx;
            key_valid <= kv_nx;
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed vector table for the keypad scanner with a keypad model
module tb_keypad_matrix_scanner;
`ifdef KEY_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif
    typedef struct {
        logic        rst;
        logic [15:0] keys;
        int          n;
        logic [3:0]  col;
        logic [7:0]  btn;
        int          pulses;
    } vec_t;
    localparam logic [15:0] K5 = 16'h0040, K34 = 16'h9000, KP = 16'h8000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] keys = 16'h0;
    int applied = 0, errs = 0, bad_onehot = 0, p, cur;
    vec_t v [21];
    keypad_if kif ();
    keypad_matrix_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (.clk(clk), .rst(rst), .kp(kif));
    always #5 clk = ~clk;
    // keypad model: a pressed key pulls its row low while its column is driven
    always_comb begin
        kif.row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!kif.col_n[c]) kif.row_n = kif.row_n & ~keys[c*4 +: 4];
    end
    // column drive must always be one-hot low
    always @(negedge clk) if ($countones(~kif.col_n) != 1) bad_onehot++;
    task automatic run(input int n, output int pc);
        pc = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (kif.key_valid) pc++;
        end
    endtask
    task automatic chk(input string name, input int act, input int exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s vec %0d: got %0h want %0h", name, cur, act, exp);
        end
    endtask
    initial begin
        v[0]  = '{1'b1, 16'h0, 2,  4'b1110, 8'h00, 0};
        v[1]  = '{1'b0, 16'h0, 8,  4'b1101, 8'h00, 0};
        v[2]  = '{1'b0, 16'h0, 8,  4'b1011, 8'h00, 0};
        v[3]  = '{1'b0, 16'h0, 8,  4'b0111, 8'h00, 0};
        v[4]  = '{1'b0, 16'h0, 8,  4'b1110, 8'h00, 0};
        v[5]  = '{1'b0, K5,    32, 4'b1101, 8'h16, 1};
        v[6]  = '{1'b0, K5,    16, 4'b1101, 8'h16, 0};
        v[7]  = '{1'b0, 16'h0, 16, 4'b1101, 8'h16, 0};
        v[8]  = '{1'b0, 16'h0, 8,  4'b1011, 8'h00, 0};
        v[9]  = '{1'b0, K5,    48, 4'b1101, 8'h16, 1};
        v[10] = '{1'b0, 16'h0, 8,  4'b1101, 8'h16, 0};
        v[11] = '{1'b0, K5,    8,  4'b1101, 8'h16, 0};
        v[12] = '{1'b0, 16'h0, 16, 4'b1101, 8'h16, 0};
        v[13] = '{1'b0, 16'h0, 8,  4'b1011, 8'h00, 0};
        v[14] = '{1'b0, K5,    40, 4'b1101, 8'h00, 0};
        v[15] = '{1'b0, 16'h0, 8,  4'b1011, 8'h00, 0};
        v[16] = '{1'b0, K34,   32, 4'b0111, 8'h34, 1};
        v[17] = '{1'b0, 16'h0, 24, 4'b1110, 8'h00, 0};
        v[18] = '{1'b0, KP,    48, 4'b0111, 8'h37, 1};
        v[19] = '{1'b1, KP,    1,  4'b1110, 8'h00, 0};
        v[20] = '{1'b0, KP,    48, 4'b0111, 8'h37, 1};
        for (int i = 0; i < 21; i++) begin
            cur  = i;
            rst  = v[i].rst;
            keys = v[i].keys;
            run(v[i].n, p);
            chk("col_n", int'(kif.col_n), int'(v[i].col));
            chk("button", int'(kif.button), (PULSE && v[i].pulses == 0) ? 0 : int'(v[i].btn));
            chk("pulses", p, v[i].pulses);
            chk("key_valid", int'(kif.key_valid), v[i].pulses);
        end
        cur = 21;
        run(1, p);
        chk("kv_one_cycle", int'(kif.key_valid), 0);
        chk("button_after_pulse", int'(kif.button), PULSE ? 0 : 8'h37);
        cur = 22;
        run(24, p);
        chk("held_no_repulse", p, 0);
        chk("held_col_frozen", int'(kif.col_n), 4'b0111);
        chk("col_onehot", bad_onehot, 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end
endmodule
